// File: rtl/rip_branch_predictor_const.sv
// Shared branch-predictor types: table index, 2-bit weight, and the in-flight tracking entry.
package rip_branch_predictor_const;

   localparam int unsigned BP_INDEX_W     = 8;
   localparam int unsigned BP_TRACK_DEPTH = 4;

   typedef logic [BP_INDEX_W-1:0] bp_index_t;

   typedef enum logic [1:0] {
      STRONGLY_NOT_TAKEN = 2'b00,
      WEAKLY_NOT_TAKEN   = 2'b01,
      WEAKLY_TAKEN       = 2'b10,
      STRONGLY_TAKEN     = 2'b11
   } bp_weight_t;

   typedef struct packed {
      bp_index_t   index;
      bp_weight_t  weight;
      logic        pred;
      logic [31:0] next_pc;
   } bp_track_entry_t;

endpackage

// File: rtl/rip_bp_track_fifo.sv
// In-order storage for predicted branches awaiting resolution, with a one-cycle flush
// that discards every entry (and any same-cycle push) on a mispredict.
module rip_bp_track_fifo
   import rip_branch_predictor_const::*;
#(
   parameter int unsigned DEPTH = BP_TRACK_DEPTH
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  bp_track_entry_t push_data,
   input  logic            pop,
   input  logic            flush,
   output bp_track_entry_t head,
   output logic            empty,
   output logic            ready
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   bp_track_entry_t  mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ready_q, ready_d;
   logic             push_eff;

   // A flush wins over a push in the same cycle: that entry is wrong-path.
   assign push_eff = push & ~flush;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (push_eff) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)      rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push_eff) - CNT_W'(pop);
      end
      ready_d = (count_d != CNT_W'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b1;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ready_q  <= ready_d;
      end
   end

   // Payload storage needs no reset; occupancy is tracked by count_q.
   always_ff @(posedge clk) begin
      if (push_eff) mem_q[wr_ptr_q] <= push_data;
   end

   assign head  = mem_q[rd_ptr_q];
   assign empty = (count_q == '0);
   assign ready = ready_q;

endmodule

// File: rtl/rip_branch_resolver.sv
// Branch resolver: checks execute outcomes against the oldest in-flight prediction,
// drives the predictor update port and redirects fetch on a mispredict.
// Optional macro BP_STATS_EN adds saturating resolve/mispredict counters.
module rip_branch_resolver
   import rip_branch_predictor_const::*;
#(
   parameter int unsigned DEPTH = BP_TRACK_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enq_valid,
   output logic        enq_ready,
   input  bp_index_t   enq_index,
   input  bp_weight_t  enq_weight,
   input  logic        enq_pred,
   input  logic [31:0] enq_next_pc,
   input  logic        stall,
   input  logic        resolve_valid,
   input  logic        resolve_taken,
   input  logic [31:0] resolve_next_pc,
   output logic        update,
   output bp_index_t   update_index,
   output bp_weight_t  update_weight,
   output logic        actual,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic        resolve_err
`ifdef BP_STATS_EN
   ,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispredicts
`endif
);

   bp_track_entry_t enq_entry;
   bp_track_entry_t head;
   logic            empty;
   logic            fifo_ready;
   logic            accept;
   logic            mis_c;

   logic        update_q, update_d;
   bp_index_t   index_q, index_d;
   bp_weight_t  weight_q, weight_d;
   logic        actual_q, actual_d;
   logic        mispredict_q, mispredict_d;
   logic [31:0] redirect_q, redirect_d;
   logic        err_q, err_d;

   assign enq_entry = '{index: enq_index, weight: enq_weight, pred: enq_pred,
                        next_pc: enq_next_pc};

   assign accept = resolve_valid & ~stall & ~empty;
   // The direction term is redundant with the next-PC compare but keeps the check self-contained.
   assign mis_c  = (resolve_next_pc != head.next_pc) || (resolve_taken != head.pred);

   rip_bp_track_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (enq_valid & fifo_ready),
      .push_data (enq_entry),
      .pop       (accept & ~mis_c),
      .flush     (accept & mis_c),
      .head      (head),
      .empty     (empty),
      .ready     (fifo_ready)
   );

   always_comb begin
      update_d     = accept;
      index_d      = index_q;
      weight_d     = weight_q;
      actual_d     = actual_q;
      mispredict_d = 1'b0;
      redirect_d   = redirect_q;
      err_d        = err_q | (resolve_valid & ~stall & empty);
      if (accept) begin
         index_d      = head.index;
         weight_d     = head.weight;
         actual_d     = resolve_taken;
         mispredict_d = mis_c;
         redirect_d   = resolve_next_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         update_q     <= 1'b0;
         index_q      <= '0;
         weight_q     <= bp_weight_t'(2'b00);
         actual_q     <= 1'b0;
         mispredict_q <= 1'b0;
         redirect_q   <= '0;
         err_q        <= 1'b0;
      end else begin
         update_q     <= update_d;
         index_q      <= index_d;
         weight_q     <= weight_d;
         actual_q     <= actual_d;
         mispredict_q <= mispredict_d;
         redirect_q   <= redirect_d;
         err_q        <= err_d;
      end
   end

   assign enq_ready     = fifo_ready;
   assign update        = update_q;
   assign update_index  = index_q;
   assign update_weight = weight_q;
   assign actual        = actual_q;
   assign mispredict    = mispredict_q;
   assign redirect_pc   = redirect_q;
   assign resolve_err   = err_q;

`ifdef BP_STATS_EN
   logic [31:0] br_cnt_q, br_cnt_d;
   logic [31:0] mis_cnt_q, mis_cnt_d;

   // Saturating event counters.
   always_comb begin
      br_cnt_d  = br_cnt_q;
      mis_cnt_d = mis_cnt_q;
      if (accept && (br_cnt_q != 32'hFFFF_FFFF))
         br_cnt_d = br_cnt_q + 32'd1;
      if (accept && mis_c && (mis_cnt_q != 32'hFFFF_FFFF))
         mis_cnt_d = mis_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         br_cnt_q  <= '0;
         mis_cnt_q <= '0;
      end else begin
         br_cnt_q  <= br_cnt_d;
         mis_cnt_q <= mis_cnt_d;
      end
   end

   assign stat_branches    = br_cnt_q;
   assign stat_mispredicts = mis_cnt_q;
`endif

endmodule

// File: tb/tb_rip_branch_resolver.sv
// Directed bench for rip_branch_resolver: basic update, mispredict flush, full/wrap,
// stall, reset mid-operation and (with BP_STATS_EN) the statistics counters.
module tb_rip_branch_resolver;
   import rip_branch_predictor_const::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        enq_valid;
   logic        enq_ready;
   bp_index_t   enq_index;
   bp_weight_t  enq_weight;
   logic        enq_pred;
   logic [31:0] enq_next_pc;
   logic        stall;
   logic        resolve_valid;
   logic        resolve_taken;
   logic [31:0] resolve_next_pc;
   logic        update;
   bp_index_t   update_index;
   bp_weight_t  update_weight;
   logic        actual;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic        resolve_err;
`ifdef BP_STATS_EN
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rip_branch_resolver dut (
      .clk             (clk),
      .rst             (rst),
      .enq_valid       (enq_valid),
      .enq_ready       (enq_ready),
      .enq_index       (enq_index),
      .enq_weight      (enq_weight),
      .enq_pred        (enq_pred),
      .enq_next_pc     (enq_next_pc),
      .stall           (stall),
      .resolve_valid   (resolve_valid),
      .resolve_taken   (resolve_taken),
      .resolve_next_pc (resolve_next_pc),
      .update          (update),
      .update_index    (update_index),
      .update_weight   (update_weight),
      .actual          (actual),
      .mispredict      (mispredict),
      .redirect_pc     (redirect_pc),
      .resolve_err     (resolve_err)
`ifdef BP_STATS_EN
      ,
      .stat_branches   (stat_branches),
      .stat_mispredicts(stat_mispredicts)
`endif
   );

   function automatic logic [31:0] npc_of(input bp_index_t idx);
      return 32'h0000_1000 + (32'(idx) << 4);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      enq_valid       = 1'b0;
      enq_index       = '0;
      enq_weight      = STRONGLY_NOT_TAKEN;
      enq_pred        = 1'b0;
      enq_next_pc     = '0;
      stall           = 1'b0;
      resolve_valid   = 1'b0;
      resolve_taken   = 1'b0;
      resolve_next_pc = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic push(input bp_index_t idx, input bp_weight_t w, input logic [31:0] npc);
      enq_valid   = 1'b1;
      enq_index   = idx;
      enq_weight  = w;
      enq_pred    = 1'b1;
      enq_next_pc = npc;
      tick();
      enq_valid   = 1'b0;
   endtask

   task automatic pop(input logic [31:0] npc);
      resolve_valid   = 1'b1;
      resolve_taken   = 1'b1;
      resolve_next_pc = npc;
      tick();
      resolve_valid   = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({update, mispredict, resolve_err, actual} !== 4'b0000) begin
         bad++; $display("FAIL reset_flags got=%b want=0000", {update, mispredict, resolve_err, actual});
      end
      total++;
      if (update_index !== 8'd0) begin
         bad++; $display("FAIL reset_index got=%0d want=0", update_index);
      end
      total++;
      if (update_weight !== STRONGLY_NOT_TAKEN) begin
         bad++; $display("FAIL reset_weight got=%0d want=0", update_weight);
      end
      total++;
      if (redirect_pc !== 32'd0) begin
         bad++; $display("FAIL reset_redirect got=%h want=0", redirect_pc);
      end
      total++;
      if (enq_ready !== 1'b1) begin
         bad++; $display("FAIL reset_enq_ready got=%b want=1", enq_ready);
      end
   endtask

   task automatic test_basic();
      do_reset();
      push(8'd5, WEAKLY_TAKEN, 32'h100);
      pop(32'h100);
      total++;
      if ({update, actual, mispredict} !== 3'b110) begin
         bad++; $display("FAIL basic_flags got=%b want=110", {update, actual, mispredict});
      end
      total++;
      if (update_index !== 8'd5 || update_weight !== WEAKLY_TAKEN) begin
         bad++; $display("FAIL basic_fields got=%0d/%0d want=5/%0d", update_index, update_weight, WEAKLY_TAKEN);
      end
      tick();
      total++;
      if (update !== 1'b0) begin
         bad++; $display("FAIL basic_pulse got=%b want=0", update);
      end
   endtask

   task automatic test_mispredict();
      do_reset();
      push(8'd1, WEAKLY_TAKEN, 32'h10);
      push(8'd2, STRONGLY_TAKEN, 32'h20);
      push(8'd3, WEAKLY_TAKEN, 32'h30);
      pop(32'h14);
      total++;
      if ({update, mispredict} !== 2'b11 || redirect_pc !== 32'h14 || update_index !== 8'd1) begin
         bad++; $display("FAIL mis_pulse got=%b pc=%h idx=%0d want=11 pc=14 idx=1", {update, mispredict}, redirect_pc, update_index);
      end
      tick();
      total++;
      if ({update, mispredict, resolve_err} !== 3'b000) begin
         bad++; $display("FAIL mis_after got=%b want=000", {update, mispredict, resolve_err});
      end
      pop(32'h20);
      total++;
      if (update !== 1'b0 || resolve_err !== 1'b1) begin
         bad++; $display("FAIL mis_flushed got=upd%b err%b want=upd0 err1", update, resolve_err);
      end
   endtask

   task automatic test_full_wrap();
      bp_index_t exp_q[$];
      bp_index_t nxt;
      do_reset();
      for (int i = 0; i < 4; i++) push(bp_index_t'(10 + i), WEAKLY_TAKEN, npc_of(bp_index_t'(10 + i)));
      total++;
      if (enq_ready !== 1'b0) begin
         bad++; $display("FAIL full_ready got=%b want=0", enq_ready);
      end
      enq_valid = 1'b1; enq_index = 8'd99; enq_weight = WEAKLY_TAKEN; enq_pred = 1'b1;
      enq_next_pc = npc_of(8'd99);
      pop(npc_of(8'd10));
      enq_valid = 1'b0;
      total++;
      if (update !== 1'b1 || update_index !== 8'd10 || enq_ready !== 1'b1) begin
         bad++; $display("FAIL full_enq_pop got=upd%b idx%0d rdy%b want=upd1 idx10 rdy1", update, update_index, enq_ready);
      end
      for (int i = 11; i < 14; i++) begin
         pop(npc_of(bp_index_t'(i)));
         total++;
         if (update !== 1'b1 || mispredict !== 1'b0 || update_index !== bp_index_t'(i)) begin
            bad++; $display("FAIL drain got=upd%b mis%b idx%0d want=upd1 mis0 idx%0d", update, mispredict, update_index, i);
         end
      end
      push(8'd30, WEAKLY_TAKEN, npc_of(8'd30)); exp_q.push_back(8'd30);
      push(8'd31, WEAKLY_TAKEN, npc_of(8'd31)); exp_q.push_back(8'd31);
      for (int i = 0; i < 6; i++) begin
         nxt = exp_q.pop_front();
         enq_valid = 1'b1; enq_index = bp_index_t'(32 + i); enq_pred = 1'b1;
         enq_next_pc = npc_of(bp_index_t'(32 + i));
         exp_q.push_back(bp_index_t'(32 + i));
         pop(npc_of(nxt));
         enq_valid = 1'b0;
         total++;
         if (update !== 1'b1 || update_index !== nxt || enq_ready !== 1'b1) begin
            bad++; $display("FAIL wrap got=upd%b idx%0d rdy%b want=upd1 idx%0d rdy1", update, update_index, enq_ready, nxt);
         end
      end
      while (exp_q.size() > 0) begin
         nxt = exp_q.pop_front();
         pop(npc_of(nxt));
         total++;
         if (update !== 1'b1 || update_index !== nxt) begin
            bad++; $display("FAIL wrap_drain got=upd%b idx%0d want=upd1 idx%0d", update, update_index, nxt);
         end
      end
      pop(npc_of(8'd99));
      total++;
      if (update !== 1'b0 || resolve_err !== 1'b1) begin
         bad++; $display("FAIL wrap_empty got=upd%b err%b want=upd0 err1", update, resolve_err);
      end
   endtask

   task automatic test_stall();
      do_reset();
      push(8'd7, WEAKLY_NOT_TAKEN, npc_of(8'd7));
      stall = 1'b1; resolve_valid = 1'b1; resolve_taken = 1'b1; resolve_next_pc = npc_of(8'd7);
      for (int i = 0; i < 3; i++) begin
         enq_valid = (i == 0); enq_index = 8'd6; enq_weight = STRONGLY_TAKEN; enq_pred = 1'b1;
         enq_next_pc = npc_of(8'd6);
         tick();
         total++;
         if (update !== 1'b0) begin
            bad++; $display("FAIL stall_hold cyc%0d got=%b want=0", i, update);
         end
      end
      enq_valid = 1'b0;
      stall = 1'b0;
      tick();
      resolve_valid = 1'b0;
      total++;
      if (update !== 1'b1 || update_index !== 8'd7 || update_weight !== WEAKLY_NOT_TAKEN) begin
         bad++; $display("FAIL stall_release got=upd%b idx%0d w%0d want=upd1 idx7 w1", update, update_index, update_weight);
      end
      tick();
      total++;
      if (update !== 1'b0 || resolve_err !== 1'b0) begin
         bad++; $display("FAIL stall_single got=upd%b err%b want=upd0 err0", update, resolve_err);
      end
      pop(npc_of(8'd6));
      total++;
      if (update !== 1'b1 || update_index !== 8'd6) begin
         bad++; $display("FAIL stall_enq got=upd%b idx%0d want=upd1 idx6", update, update_index);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      push(8'd8, STRONGLY_TAKEN, npc_of(8'd8));
      pop(npc_of(8'd8));
      total++;
      if (update !== 1'b1) begin
         bad++; $display("FAIL rmid_pre got=%b want=1", update);
      end
      rst = 1'b1;
      tick();
      total++;
      if ({update, mispredict, actual, resolve_err, enq_ready} !== 5'b00001 ||
          update_index !== 8'd0 || redirect_pc !== 32'd0) begin
         bad++; $display("FAIL rmid_zero got=%b idx%0d pc%h want=00001 idx0 pc0", {update, mispredict, actual, resolve_err, enq_ready}, update_index, redirect_pc);
      end
      rst = 1'b0;
      push(8'd9, WEAKLY_TAKEN, npc_of(8'd9));
      push(8'd10, WEAKLY_TAKEN, npc_of(8'd10));
      rst = 1'b1; resolve_valid = 1'b1; resolve_taken = 1'b1; resolve_next_pc = npc_of(8'd9);
      tick();
      total++;
      if (update !== 1'b0) begin
         bad++; $display("FAIL rmid_accept got=%b want=0", update);
      end
      rst = 1'b0;
      tick();
      resolve_valid = 1'b0;
      total++;
      if (update !== 1'b0 || resolve_err !== 1'b1) begin
         bad++; $display("FAIL rmid_discard got=upd%b err%b want=upd0 err1", update, resolve_err);
      end
   endtask

`ifdef BP_STATS_EN
   task automatic test_stats();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         push(bp_index_t'(i), WEAKLY_TAKEN, npc_of(bp_index_t'(i)));
         pop((i == 2 || i == 5 || i == 8) ? 32'hDEAD_0000 : npc_of(bp_index_t'(i)));
      end
      total++;
      if (stat_branches !== 32'd10 || stat_mispredicts !== 32'd3) begin
         bad++; $display("FAIL stats got=%0d/%0d want=10/3", stat_branches, stat_mispredicts);
      end
   endtask
`endif

   initial begin
      clear_inputs();
      rst = 1'b1;
      test_reset();
      test_basic();
      test_mispredict();
      test_full_wrap();
      test_stall();
      test_reset_mid();
`ifdef BP_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
